// File: rtl/out_port_arbiter_pkg.sv
// Shared router definitions: port one-hot codes, arbiter state codes.
// Imported by the output-port arbiter and its round-robin picker.
package out_port_arbiter_pkg;

    localparam int NUM_PORTS = 5;

    localparam logic [NUM_PORTS-1:0] N_PORT = 5'b00001;
    localparam logic [NUM_PORTS-1:0] E_PORT = 5'b00010;
    localparam logic [NUM_PORTS-1:0] W_PORT = 5'b00100;
    localparam logic [NUM_PORTS-1:0] S_PORT = 5'b01000;
    localparam logic [NUM_PORTS-1:0] L_PORT = 5'b10000;

    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_e;

endpackage

// File: rtl/rr_pick5.sv
// Combinational round-robin picker over the five router inputs.
// Ports: req (requests), last (one-hot previous owner), mask (bits to
// exclude), pick (one-hot winner, 0 when nothing eligible).
module rr_pick5
    import out_port_arbiter_pkg::*;
(
    input  logic [NUM_PORTS-1:0] req,
    input  logic [NUM_PORTS-1:0] last,
    input  logic [NUM_PORTS-1:0] mask,
    output logic [NUM_PORTS-1:0] pick
);

    always_comb begin
        int start;
        int idx;
        logic [NUM_PORTS-1:0] cand;
        cand  = req & ~mask;
        pick  = '0;
        start = 0;
        idx   = 0;
        // Search begins at the port just after the previous owner.
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (last[i]) start = (i + 1) % NUM_PORTS;
        end
        for (int k = 0; k < NUM_PORTS; k++) begin
            idx = (start + k) % NUM_PORTS;
            if (cand[idx] && (pick == '0)) pick[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/out_port_arbiter.sv
// Per-output-port wormhole switch allocator: round-robin owner held for a
// whole packet, driving crossbar select (sel_out) and FIFO pops (grant).
// Ports: clk, rst (sync, active high), req, tail_in, out_ready in;
// sel_out, grant, busy, wdog_err out.
// Optional stall watchdog: define ARB_WATCHDOG_EN.
module out_port_arbiter
    import out_port_arbiter_pkg::*;
#(
    parameter int WDOG_CYCLES = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_PORTS-1:0] req,
    input  logic [NUM_PORTS-1:0] tail_in,
    input  logic                 out_ready,
    output logic [NUM_PORTS-1:0] sel_out,
    output logic [NUM_PORTS-1:0] grant,
    output logic                 busy,
    output logic                 wdog_err
);

    arb_state_e           state_q;
    logic [NUM_PORTS-1:0] sel_q;
    logic [NUM_PORTS-1:0] last_q;
    logic [NUM_PORTS-1:0] pick;
    logic [NUM_PORTS-1:0] pick_last;
    logic                 tail_xfer;

    // In IDLE sel_q is zero, so one picker serves both the fresh pick
    // (pointer last_q, no mask) and the tail re-arbitration (pointer and
    // mask both equal to the departing owner).
    assign pick_last = (state_q == ARB_LOCKED) ? sel_q : last_q;

    rr_pick5 u_pick (
        .req  (req),
        .last (pick_last),
        .mask (sel_q),
        .pick (pick)
    );

    assign grant     = sel_q & req & {NUM_PORTS{out_ready}};
    assign tail_xfer = |(grant & tail_in);
    assign sel_out   = sel_q;
    assign busy      = (state_q == ARB_LOCKED);

`ifdef ARB_WATCHDOG_EN
    localparam int CW = $clog2(WDOG_CYCLES + 1);

    logic [CW-1:0] wd_cnt_q;
    logic          wdog_err_q;
    logic          wd_hit;

    // True when this stalled cycle brings the count up to WDOG_CYCLES.
    assign wd_hit   = (wd_cnt_q >= CW'(WDOG_CYCLES - 1));
    assign wdog_err = wdog_err_q;
`else
    logic unused_wdog;
    assign unused_wdog = (WDOG_CYCLES == 0);
    assign wdog_err    = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ARB_IDLE;
            sel_q   <= '0;
            last_q  <= L_PORT;
`ifdef ARB_WATCHDOG_EN
            wd_cnt_q   <= '0;
            wdog_err_q <= 1'b0;
`endif
        end else begin
`ifdef ARB_WATCHDOG_EN
            wdog_err_q <= 1'b0;
`endif
            unique case (state_q)
                ARB_IDLE: begin
                    if (|req) begin
                        sel_q   <= pick;
                        state_q <= ARB_LOCKED;
`ifdef ARB_WATCHDOG_EN
                        wd_cnt_q <= '0;
`endif
                    end
                end
                ARB_LOCKED: begin
                    if (tail_xfer) begin
                        last_q <= sel_q;
                        sel_q  <= pick;
                        if (pick == '0) state_q <= ARB_IDLE;
`ifdef ARB_WATCHDOG_EN
                        wd_cnt_q <= '0;
                    end else if (|grant) begin
                        wd_cnt_q <= '0;
                    end else if (wd_hit) begin
                        state_q    <= ARB_IDLE;
                        sel_q      <= '0;
                        last_q     <= sel_q;
                        wdog_err_q <= 1'b1;
                        wd_cnt_q   <= '0;
                    end else if (wd_cnt_q != CW'(WDOG_CYCLES)) begin
                        wd_cnt_q <= wd_cnt_q + 1'b1;
`endif
                    end
                end
                default: begin
                    state_q <= ARB_IDLE;
                    sel_q   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_out_port_arbiter.sv
// Scoreboard bench for out_port_arbiter: expected grants queued by the
// stimulus, popped and compared by a monitor on every nonzero grant.
module tb_out_port_arbiter;

    logic       clk;
    logic       rst;
    logic [4:0] req;
    logic [4:0] tail_in;
    logic       out_ready;
    logic [4:0] sel_out;
    logic [4:0] grant;
    logic       busy;
    logic       wdog_err;

    int tests;
    int fails;
    logic [4:0] exp_q[$];

    out_port_arbiter #(.WDOG_CYCLES(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .tail_in   (tail_in),
        .out_ready (out_ready),
        .sel_out   (sel_out),
        .grant     (grant),
        .busy      (busy),
        .wdog_err  (wdog_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [4:0] act,
                       input logic [4:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %b expected %b at %0t",
                     nm, act, exp, $time);
        end
    endtask

    // Monitor: every presented grant must match the head of the queue.
    initial begin
        logic [4:0] e;
        forever begin
            @(negedge clk);
            if (grant != 5'b0) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL grant_unexpected: got %b expected none at %0t",
                             grant, $time);
                end else begin
                    e = exp_q.pop_front();
                    chk("grant", grant, e);
                end
            end
        end
    end

    // One cycle: drive inputs, queue expected grant, check state outputs.
    task automatic step(input logic [4:0] r, input logic [4:0] t,
                        input logic rdy, input logic [4:0] eg,
                        input logic [4:0] es, input logic eb,
                        input logic ew, input string nm);
        req       = r;
        tail_in   = t;
        out_ready = rdy;
        if (eg != 5'b0) exp_q.push_back(eg);
        @(negedge clk);
        chk({nm, "_sel"}, sel_out, es);
        chk({nm, "_busy"}, {4'b0, busy}, {4'b0, eb});
        chk({nm, "_wdog"}, {4'b0, wdog_err}, {4'b0, ew});
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        req       = '0;
        tail_in   = '0;
        out_ready = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        clk   = 1'b0;
        tests = 0;
        fails = 0;
        do_reset();
        @(negedge clk);
        chk("rst_sel", sel_out, 5'b0);
        chk("rst_grant", grant, 5'b0);
        chk("rst_busy", {4'b0, busy}, 5'b0);
        chk("rst_wdog", {4'b0, wdog_err}, 5'b0);
        @(posedge clk);
        #1;

        // N requests, then E joins for 3 flits, N tail hands over to E.
        step(5'b00001, 5'b00000, 1, 5'b00000, 5'b00000, 0, 0, "n_req");
        step(5'b00001, 5'b00000, 1, 5'b00001, 5'b00001, 1, 0, "n_lock");
        for (int i = 0; i < 3; i++)
            step(5'b00011, 5'b00000, 1, 5'b00001, 5'b00001, 1, 0, "n_hold");
        step(5'b00011, 5'b00001, 1, 5'b00001, 5'b00001, 1, 0, "n_tail");
        step(5'b00010, 5'b00010, 1, 5'b00010, 5'b00010, 1, 0, "e_own");
        step(5'b00000, 5'b00000, 1, 5'b00000, 5'b00000, 0, 0, "e_idle");

        // All five stream single-flit packets: rotation N,E,W,S,L,N.
        do_reset();
        step(5'b11111, 5'b11111, 1, 5'b00000, 5'b00000, 0, 0, "rr_start");
        step(5'b11111, 5'b11111, 1, 5'b00001, 5'b00001, 1, 0, "rr_n");
        step(5'b11111, 5'b11111, 1, 5'b00010, 5'b00010, 1, 0, "rr_e");
        step(5'b11111, 5'b11111, 1, 5'b00100, 5'b00100, 1, 0, "rr_w");
        step(5'b11111, 5'b11111, 1, 5'b01000, 5'b01000, 1, 0, "rr_s");
        step(5'b11111, 5'b11111, 1, 5'b10000, 5'b10000, 1, 0, "rr_l");
        step(5'b11111, 5'b11111, 1, 5'b00001, 5'b00001, 1, 0, "rr_n2");
        step(5'b00010, 5'b00010, 1, 5'b00010, 5'b00010, 1, 0, "rr_e2");
        step(5'b00000, 5'b00000, 1, 5'b00000, 5'b00000, 0, 0, "rr_idle");

        // Pointer at E: W wins, tail stalled by out_ready for 4 cycles.
        step(5'b00100, 5'b00000, 1, 5'b00000, 5'b00000, 0, 0, "w_req");
        for (int i = 0; i < 4; i++)
            step(5'b00100, 5'b00100, 0, 5'b00000, 5'b00100, 1, 0, "w_stall");
        step(5'b00100, 5'b00100, 1, 5'b00100, 5'b00100, 1, 0, "w_tail");
        step(5'b00000, 5'b00000, 1, 5'b00000, 5'b00000, 0, 0, "w_idle");

        // Pointer at W: S wins, then reset mid-packet.
        step(5'b01000, 5'b00000, 1, 5'b00000, 5'b00000, 0, 0, "s_req");
        step(5'b01000, 5'b00000, 1, 5'b01000, 5'b01000, 1, 0, "s_lock");
        rst     = 1'b1;
        req     = '0;
        tail_in = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        step(5'b11111, 5'b00000, 1, 5'b00000, 5'b00000, 0, 0, "s_rst");
        step(5'b11111, 5'b00000, 1, 5'b00001, 5'b00001, 1, 0, "s_pick_n");
        // Owner FIFO empty mid-packet: lock held, no one else granted.
        step(5'b11110, 5'b00000, 1, 5'b00000, 5'b00001, 1, 0, "n_empty");
        step(5'b11111, 5'b00001, 1, 5'b00001, 5'b00001, 1, 0, "n_tail2");
        step(5'b00010, 5'b00010, 1, 5'b00010, 5'b00010, 1, 0, "e_tail2");
        step(5'b00000, 5'b00000, 1, 5'b00000, 5'b00000, 0, 0, "e_idle2");

        // Pointer at E: L wins, then L goes silent for 8 cycles.
        step(5'b10000, 5'b00000, 1, 5'b00000, 5'b00000, 0, 0, "l_req");
        step(5'b10000, 5'b00000, 1, 5'b10000, 5'b10000, 1, 0, "l_lock");
        for (int i = 0; i < 8; i++)
            step(5'b00000, 5'b00000, 1, 5'b00000, 5'b10000, 1, 0, "l_stall");
`ifdef ARB_WATCHDOG_EN
        step(5'b00000, 5'b00000, 1, 5'b00000, 5'b00000, 0, 1, "wd_fire");
        step(5'b00000, 5'b00000, 1, 5'b00000, 5'b00000, 0, 0, "wd_after");
`else
        step(5'b00000, 5'b00000, 1, 5'b00000, 5'b10000, 1, 0, "l_persist");
        step(5'b00000, 5'b00000, 1, 5'b00000, 5'b10000, 1, 0, "l_persist2");
`endif

        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL grant_missing: got %0d left expected 0",
                     exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/out_port_arbiter.md
# out_port_arbiter

Per-output-port switch allocator of the 5-port wormhole router. Collects requests from the N, E, W, S and L input buffers that target this output, selects one owner round-robin, and holds that choice for the whole packet, header through tail. Drives the one-hot select of the output crossbar mux that sits directly downstream, and the read-enables of the input FIFOs. There is one instance per output port.

## Interface
- `WDOG_CYCLES`, default 255: consecutive no-grant cycles while locked before a forced release. Used only with the watchdog compiled in.
- `clk` in 1: router clock. Single clock domain.
- `rst` in 1: synchronous, active-high reset.
- `req` in 5: bit i is high when input i has a flit at its FIFO head destined for this output. Bit order matches the port codes: bit0=N, bit1=E, bit2=W, bit3=S, bit4=L.
- `tail_in` in 5: bit i is high when the head flit of input i is a tail (single-flit packets assert header and tail together).
- `out_ready` in 1: downstream link accepts a flit this cycle.
- `sel_out` out 5: registered one-hot owner using the `N_PORT`..`L_PORT` codes, or 0 when idle. Connects to the crossbar `sel_in`.
- `grant` out 5: combinational, equal to `sel_out & req & {5{out_ready}}`. Serves as the FIFO read-enable; a flit transfers in any cycle where grant≠0.
- `busy` out 1: high in state LOCKED.
- `wdog_err` out 1: one-cycle pulse on a forced release. Tied to 0 when the watchdog is compiled out.

## Operation
- FSM states: IDLE and LOCKED.
- Registers:
  - `state`
  - `sel_q` (5-bit, drives `sel_out`)
  - `last_q` (5-bit one-hot, last owner)
  - watchdog counter (optional)
- Reset values: `state`=IDLE, `sel_out`=0, `grant`=0, `busy`=0, `wdog_err`=0, `last_q`=`L_PORT` (N has highest priority after reset).
- Round-robin pick:
  - Searches cyclically N→E→W→S→L, starting at the port after `last_q`.
  - The winner is the first asserted `req` bit.
  - `pick`=0 when `req`=0.
- IDLE:
  - If `req`≠0: `sel_q`←pick, `state`←LOCKED.
  - Otherwise stay in IDLE with `sel_out`=0.
- LOCKED, normal flit:
  - A flit moves when `grant`≠0.
  - `sel_q` never changes on a non-tail transfer. Requests from other inputs are ignored.
- LOCKED, tail transfer (`grant`≠0 and `tail_in` of the owner set):
  - `last_q`←`sel_q`.
  - Re-arbitrate in the same cycle among `req` with the owner's bit masked off, using the updated pointer.
  - If another input is requesting: `sel_q`←winner, stay LOCKED. There is no bubble.
  - If no other input is requesting: `sel_q`←0, `state`←IDLE.
- LOCKED, owner `req` low (owner FIFO empty mid-packet): hold the lock, `grant`=0, wait. Other inputs are never granted mid-packet.
- `out_ready` low: `grant`=0 and the state is held. A tail only counts when it is granted.
- `rst` asserted mid-packet: the next edge returns the block to IDLE, `sel_out`=0, with the pointer reset. Packet recovery is the system's concern.
- `grant` is always a subset of `sel_out`, and both are one-hot or zero.

## Timing
- Latency from request to selection:
  - `req` rising in IDLE at cycle t gives `sel_out` valid at t+1.
  - The first `grant` is at t+1 if `out_ready` is high.
- Back-to-back packets: tail granted at cycle t gives the new owner's `sel_out` at t+1. Sustained throughput is one flit per cycle.
- `grant` settles combinationally in the same cycle from `sel_q`, `req` and `out_ready`. The crossbar output and the FIFO pop happen in the same cycle.
- `wdog_err` is asserted for exactly the one cycle after the forcing edge.

## Configuration
- `ARB_WATCHDOG_EN` defined:
  - A counter of width `$clog2(WDOG_CYCLES+1)` clears on entry to LOCKED and on every grant, and increments each LOCKED cycle with `grant`=0.
  - When the count reaches `WDOG_CYCLES`:
    - `state`←IDLE
    - `sel_q`←0
    - `last_q`←owner
    - `wdog_err` pulses
  - The counter saturates and never wraps.
- Undefined: no counter logic, `wdog_err`=0 constant, and a stalled lock persists indefinitely.

## Structure
- Shared defines header holds:
  - the port one-hot codes `N_PORT`..`L_PORT` (existing)
  - new `ARB_IDLE`/`ARB_LOCKED` state codes
  - `NUM_PORTS`=5
- One sub-module, `rr_pick5`: a combinational round-robin picker with inputs (`req`, `last`, `mask`) and a one-hot output. It is reused by the IDLE pick and the tail re-arbitration.

## Test plan
- Reset, then `req`=00001 (N), `tail_in`=0, `out_ready`=1 → `sel_out`=00001 one cycle later, `grant`=00001, `busy`=1.
- N owns the lock and `req` becomes 00011 (E joins) for 3 flits, then N's tail → `grant` stays 00001 throughout, then `sel_out`=00010 the cycle after the tail with no idle gap.
- All 5 inputs request single-flit packets continuously after reset → grants rotate N,E,W,S,L,N, one per cycle.
- Locked on W, `out_ready` held 0 for 4 cycles with W's tail at the head → `grant`=0 and lock held, then release one cycle after `out_ready` returns.
- Locked on S, `rst`=1 for one cycle mid-packet → next cycle `sel_out`=0, `busy`=0, then the next pick favours N.
- `ARB_WATCHDOG_EN`, `WDOG_CYCLES`=8: lock on L, then `req`[4]=0 for 8 cycles → `wdog_err` pulses once, `sel_out`=0, `busy`=0.
